// File: rtl/decoder3to8_seq.sv
// -----------------------------------------------------------------------------
// decoder3to8_seq
//   Sequenced 3-to-8 decoder. A 3-bit code is accepted over a valid/ready
//   handshake. The matching one-hot line is driven on y for HOLD_CYCLES cycles.
//   y is then forced to zero for GAP_CYCLES cycles before the next code can be
//   taken. This turns codes from the 8-to-3 encoder path back into timed
//   one-hot strobes for select and enable fan-out.
//
// Parameters
//   HOLD_CYCLES  cycles y stays one-hot per accepted code (>= 1)
//   GAP_CYCLES   cycles y is held at zero after each hold (>= 0)
//   CNT_W        counter width; both cycle counts must be <= 2**CNT_W
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous, active-low reset
//   en          in   block enable; low aborts a hold or gap in progress
//   code_in     in   [2:0] code to decode
//   code_valid  in   code_in is valid
//   code_par    in   expected parity of code_in (DEC_PARITY_CHK_EN only)
//   code_ready  out  block can accept a code (combinational)
//   y           out  [7:0] registered one-hot output
//   busy        out  registered, high in HOLD or GAP
//   done        out  registered one-cycle pulse at the normal end of a hold
//   par_err     out  registered one-cycle pulse on a parity-rejected transfer
//                    (DEC_PARITY_CHK_EN only)
//   dbg_state   out  [1:0] current FSM state, for observation only
//
// Configuration macro
//   DEC_PARITY_CHK_EN  adds code_par / par_err and parity-checks each transfer
// -----------------------------------------------------------------------------
module decoder3to8_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] code_in,
    input  logic       code_valid,
`ifdef DEC_PARITY_CHK_EN
    input  logic       code_par,
    output logic       par_err,
`endif
    output logic       code_ready,
    output logic [7:0] y,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // Counter reload values. The counter counts down to zero, so a phase of
    // N cycles loads N-1. A zero-length gap never loads, so clamp it to 0.
    localparam int HOLD_LOAD_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int GAP_LOAD_I  = (GAP_CYCLES  > 0) ? GAP_CYCLES  - 1 : 0;
    localparam logic [CNT_W-1:0] HOLD_LOAD = HOLD_LOAD_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] GAP_LOAD  = GAP_LOAD_I[CNT_W-1:0];

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             code_ok;

    // Handshake: a transfer happens on a rising edge where code_valid and
    // code_ready are both high. code_ready depends only on state, en and
    // rst_n, never on code_valid. A producer may present code_valid at any
    // time. Once a code is offered, the producer holds it until it is taken.
    assign code_ready = rst_n && en && (state == S_IDLE);
    assign accept     = code_valid && code_ready;
    assign dbg_state  = state;

`ifdef DEC_PARITY_CHK_EN
    assign code_ok = (code_par == ^code_in);
`else
    assign code_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            y     <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DEC_PARITY_CHK_EN
            par_err <= 1'b0;
`endif
        end else begin
            // done and par_err are single-cycle pulses.
            done <= 1'b0;
`ifdef DEC_PARITY_CHK_EN
            par_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (code_ok) begin
                            y     <= 8'h01 << code_in;
                            busy  <= 1'b1;
                            cnt   <= HOLD_LOAD;
                            state <= S_HOLD;
                        end else begin
                            // A bad-parity code is consumed but is not decoded.
`ifdef DEC_PARITY_CHK_EN
                            par_err <= 1'b1;
`endif
                        end
                    end
                end

                S_HOLD: begin
                    // Abort wins over the normal end of a hold.
                    if (!en) begin
                        y     <= 8'h00;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        y    <= 8'h00;
                        done <= 1'b1;
                        if (GAP_CYCLES > 0) begin
                            cnt   <= GAP_LOAD;
                            state <= S_GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_GAP: begin
                    if (!en) begin
                        y     <= 8'h00;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    y     <= 8'h00;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
